// File: rtl/cnn1d_pkg.sv
// Shared CNN 1-D package: common types and helper functions for the conv
// pipeline blocks. Holds the two-state serializer FSM encoding.
package cnn1d_pkg;

  // Ceiling log2. Never returns less than 1, so every index signal has at
  // least one bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  // Serializer states. LOAD waits for a full channel vector. SHIFT emits the
  // captured vector one channel per beat.
  typedef enum logic {
    LOAD  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage : cnn1d_pkg

// File: rtl/conv1d_layer_serializer_if.sv
// Bus interface for conv1d_layer_serializer.
// Input side: the parallel conv layer output (per-channel valid, one word per
// channel, one shared ready).
// Output side: the serial word stream with channel index and last flag.
// The slave modport is the serializer's view. The master modport is the view
// of the environment that drives the conv side and sinks the stream.
interface conv1d_layer_serializer_if
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHANNELS = 32
);
  localparam int COUNTER_WIDTH = clog2(NUM_CHANNELS);

  // Parallel side
  logic                     ser_ready_in;
  logic [NUM_CHANNELS-1:0]  ser_valid_in;
  logic [DATA_WIDTH-1:0]    ser_data_in [0:NUM_CHANNELS-1];

  // Serial side
  logic                     ser_ready_out;
  logic                     ser_valid_out;
  logic [DATA_WIDTH-1:0]    ser_data_out;
  logic [COUNTER_WIDTH-1:0] ser_channel_out;
  logic                     ser_last_out;

  // Status
  logic                     ser_error;

  modport slave (
    output ser_ready_in,
    input  ser_valid_in,
    input  ser_data_in,
    input  ser_ready_out,
    output ser_valid_out,
    output ser_data_out,
    output ser_channel_out,
    output ser_last_out,
    output ser_error
  );

  modport master (
    input  ser_ready_in,
    output ser_valid_in,
    output ser_data_in,
    output ser_ready_out,
    input  ser_valid_out,
    input  ser_data_out,
    input  ser_channel_out,
    input  ser_last_out,
    input  ser_error
  );

endinterface : conv1d_layer_serializer_if

// File: rtl/conv1d_layer_serializer.sv
// conv1d_layer_serializer: captures one full conv channel vector per
// handshake and replays it one channel per beat, channel 0 first.
// Optional macro CONV1D_SER_VALID_CHECK_EN adds a sticky flag, ser_error. The
// flag sets in any cycle where the per-channel valid vector is neither all-zeros
// nor all-ones. Without the macro, ser_error is constant 0.
module conv1d_layer_serializer
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHANNELS = 32
) (
  input  logic clk,
  input  logic rst,
  conv1d_layer_serializer_if.slave bus
);

  localparam int COUNTER_WIDTH = clog2(NUM_CHANNELS);
  localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(NUM_CHANNELS - 1);

  ser_state_t               state_q, state_d;
  logic [COUNTER_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]    buf_q [0:NUM_CHANNELS-1];
  logic [DATA_WIDTH-1:0]    buf_d [0:NUM_CHANNELS-1];

  logic valid_out;
  logic last_out;
  logic ready_in;
  logic accept;

  // Next-state, capture and output logic. A vector can be accepted on the final
  // beat of the previous one, so there is no bubble between vectors.
  always_comb begin
    // NOTE: every signal gets a default before any branch. An incomplete
    // assignment path in always_comb would infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;

    valid_out = !rst && (state_q == SHIFT);
    last_out  = valid_out && (idx_q == LAST_IDX);
    ready_in  = !rst && ((state_q == LOAD) || (last_out && bus.ser_ready_out));
    accept    = ready_in && (&bus.ser_valid_in);

    if (accept) begin
      buf_d = bus.ser_data_in;
    end

    unique case (state_q)
      LOAD: begin
        if (accept) begin
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ser_ready_out) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = accept ? SHIFT : LOAD;
          end else begin
            idx_d   = idx_q + COUNTER_WIDTH'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    bus.ser_ready_in    = ready_in;
    bus.ser_valid_out   = valid_out;
    bus.ser_last_out    = last_out;
    bus.ser_data_out    = valid_out ? buf_q[idx_q] : '0;
    bus.ser_channel_out = valid_out ? idx_q : '0;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples
    // values from before the edge, whatever the order of the statements.
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Capture buffer. It is only read while SHIFT holds a freshly loaded vector.
  always_ff @(posedge clk) begin
    // NOTE: the data buffer is deliberately not reset. Its contents are never
    // observed before a load overwrites them, and a reset would cost a mux on
    // every bit.
    buf_q <= buf_d;
  end

`ifdef CONV1D_SER_VALID_CHECK_EN
  logic error_q, error_d;

  // Sticky flag for a partially valid channel vector, checked in both states.
  always_comb begin
    error_d = error_q | ((|bus.ser_valid_in) & ~(&bus.ser_valid_in));
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) error_q <= 1'b0;
    else     error_q <= error_d;
  end

  assign bus.ser_error = error_q;
`else
  assign bus.ser_error = 1'b0;
`endif

endmodule : conv1d_layer_serializer

// File: tb/tb_conv1d_layer_serializer.sv
// Directed bench for conv1d_layer_serializer with NUM_CHANNELS=4, DATA_WIDTH=8.
// Inputs change 2 time units after a rising edge. Outputs are checked 1 unit
// later, well clear of the next edge.
module tb_conv1d_layer_serializer;

  localparam int DW = 8;
  localparam int NC = 4;

`ifdef CONV1D_SER_VALID_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  conv1d_layer_serializer_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC)) sif ();

  conv1d_layer_serializer #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  always #5 clk = ~clk;

  // Safety net: the run has a fixed length, so exceeding this time is a hang.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach its summary line");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic set_vec(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    sif.ser_data_in[0] = d0;
    sif.ser_data_in[1] = d1;
    sif.ser_data_in[2] = d2;
    sif.ser_data_in[3] = d3;
  endtask

  // Check one presented beat (valid must be high).
  task automatic beat(input string tag, input logic [DW-1:0] d, input int ch,
                      input logic last, input logic rdy_in);
    check({tag, ".valid"}, 32'(sif.ser_valid_out), 32'd1);
    check({tag, ".data"},  32'(sif.ser_data_out),  32'(d));
    check({tag, ".ch"},    32'(sif.ser_channel_out), 32'(ch));
    check({tag, ".last"},  32'(sif.ser_last_out),  32'(last));
    check({tag, ".rdy_in"}, 32'(sif.ser_ready_in), 32'(rdy_in));
  endtask

  // Check the idle state (no valid beat, outputs forced low).
  task automatic idle(input string tag, input logic rdy_in);
    check({tag, ".valid"}, 32'(sif.ser_valid_out), 32'd0);
    check({tag, ".data"},  32'(sif.ser_data_out),  32'd0);
    check({tag, ".ch"},    32'(sif.ser_channel_out), 32'd0);
    check({tag, ".last"},  32'(sif.ser_last_out),  32'd0);
    check({tag, ".rdy_in"}, 32'(sif.ser_ready_in), 32'(rdy_in));
  endtask

  logic [DW-1:0] bp_data [0:6];
  int            bp_ch   [0:6];
  logic          bp_rdy  [0:6];
  logic [DW-1:0] b2b     [0:7];
  int            xfers;

  initial begin
    // Backpressure script: ready pattern and the word expected each cycle.
    bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bp_data = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44};
    bp_ch   = '{0, 1, 1, 1, 2, 2, 3};
    b2b     = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

    // ---- 1. Reset held 3 cycles with all channels valid ----
    rst = 1'b1;
    sif.ser_valid_in  = 4'b1111;
    sif.ser_ready_out = 1'b0;
    set_vec(8'hF0, 8'hF1, 8'hF2, 8'hF3);
    for (int i = 0; i < 3; i++) begin
      nxt();
      #1;
      idle("rst", 1'b0);
      check("rst.err", 32'(sif.ser_error), 32'd0);
    end
    rst = 1'b0;
    sif.ser_valid_in = 4'b0000;
    #1;
    idle("post_rst", 1'b1);

    // ---- 2. Single vector, no stalls ----
    set_vec(8'h11, 8'h22, 8'h33, 8'h44);
    sif.ser_valid_in  = 4'b1111;
    sif.ser_ready_out = 1'b1;
    #1;
    idle("s2.load", 1'b1);
    nxt();
    sif.ser_valid_in = 4'b0000;
    #1; beat("s2.b0", 8'h11, 0, 1'b0, 1'b0);
    nxt(); #1; beat("s2.b1", 8'h22, 1, 1'b0, 1'b0);
    nxt(); #1; beat("s2.b2", 8'h33, 2, 1'b0, 1'b0);
    nxt(); #1; beat("s2.b3", 8'h44, 3, 1'b1, 1'b1);
    nxt(); #1; idle("s2.done", 1'b1);

    // ---- 3. Backpressure on the same vector ----
    sif.ser_valid_in = 4'b1111;
    nxt();
    sif.ser_valid_in = 4'b0000;
    xfers = 0;
    for (int i = 0; i < 7; i++) begin
      sif.ser_ready_out = bp_rdy[i];
      #1;
      beat($sformatf("s3.c%0d", i), bp_data[i], bp_ch[i], (i == 6), (i == 6));
      if (sif.ser_valid_out && sif.ser_ready_out) xfers++;
      nxt();
    end
    #1;
    idle("s3.done", 1'b1);
    check("s3.xfers", 32'(xfers), 32'd4);

    // ---- 4. Back-to-back vectors A then B ----
    set_vec(8'h01, 8'h02, 8'h03, 8'h04);
    sif.ser_valid_in  = 4'b1111;
    sif.ser_ready_out = 1'b1;
    nxt();
    set_vec(8'h05, 8'h06, 8'h07, 8'h08);
    for (int i = 0; i < 8; i++) begin
      #1;
      beat($sformatf("s4.b%0d", i), b2b[i], i % 4, (i % 4 == 3), (i == 3) || (i == 7));
      nxt();
      if (i == 3) sif.ser_valid_in = 4'b0000;
    end
    #1;
    idle("s4.done", 1'b1);

    // ---- 5. Partial valid for 5 cycles ----
    sif.ser_valid_in = 4'b0111;
    #1;
    idle("s5.c0", 1'b1);
    check("s5.err0", 32'(sif.ser_error), 32'd0);
    for (int i = 1; i < 5; i++) begin
      nxt(); #1;
      idle($sformatf("s5.c%0d", i), 1'b1);
      check($sformatf("s5.err%0d", i), 32'(sif.ser_error), 32'(ERR_EN));
    end
    sif.ser_valid_in = 4'b0000;
    nxt(); #1;
    idle("s5.after", 1'b1);
    check("s5.sticky", 32'(sif.ser_error), 32'(ERR_EN));

    // ---- 6. Reset in the middle of a vector ----
    set_vec(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    sif.ser_valid_in = 4'b1111;
    nxt();
    sif.ser_valid_in = 4'b0000;
    #1; beat("s6.b0", 8'hAA, 0, 1'b0, 1'b0);
    nxt(); #1; beat("s6.b1", 8'hBB, 1, 1'b0, 1'b0);
    nxt(); #1; beat("s6.b2", 8'hCC, 2, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    idle("s6.in_rst", 1'b0);
    nxt();
    rst = 1'b0;
    #1;
    idle("s6.post_rst", 1'b1);
    check("s6.err_clr", 32'(sif.ser_error), 32'd0);
    set_vec(8'h10, 8'h20, 8'h30, 8'h40);
    sif.ser_valid_in = 4'b1111;
    nxt();
    sif.ser_valid_in = 4'b0000;
    #1; beat("s6.n0", 8'h10, 0, 1'b0, 1'b0);
    nxt(); #1; beat("s6.n1", 8'h20, 1, 1'b0, 1'b0);
    nxt(); #1; beat("s6.n2", 8'h30, 2, 1'b0, 1'b0);
    nxt(); #1; beat("s6.n3", 8'h40, 3, 1'b1, 1'b1);
    nxt(); #1; idle("s6.done", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_conv1d_layer_serializer

// File: doc/conv1d_layer_serializer.md
Name: conv1d_layer_serializer

Overview:
- Receiving end of the parallel conv layer output interface. Takes a per-filter valid vector, NUM_CHANNELS data words and one shared ready.
- Captures one complete channel vector per handshake, then emits it one channel per beat on a single valid/ready stream, channel 0 first, with channel index and last flag.
- Sits between the conv layer and downstream pooling/dense stages that consume one word at a time.

Parameters:
- DATA_WIDTH, 32, bit width of each channel word.
- NUM_CHANNELS, 32, number of parallel input channels (equals upstream filter count); must be >= 2.
- COUNTER_WIDTH, clog2(NUM_CHANNELS), localparam, width of channel index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ser_ready_in  out  1  to upstream shared ready.
- ser_valid_in  in  NUM_CHANNELS  per-channel valid from upstream.
- ser_data_in  in  DATA_WIDTH x [0:NUM_CHANNELS-1]  unpacked array of channel words.
- ser_ready_out  in  1  downstream ready.
- ser_valid_out  out  1  output word valid.
- ser_data_out  out  DATA_WIDTH  current channel word.
- ser_channel_out  out  COUNTER_WIDTH  index of current word.
- ser_last_out  out  1  high on the beat for channel NUM_CHANNELS-1.
- ser_error  out  1  sticky valid-mismatch flag; tied 0 unless the macro is defined.

Behaviour:
- Reset is synchronous: rst sampled at posedge clk.
  - state<=LOAD, idx<=0, error<=0.
  - While rst is high: ser_ready_in=0, ser_valid_out=0, ser_last_out=0, ser_channel_out=0, ser_data_out=0.
- Capture buffer buf[0:NUM_CHANNELS-1] is not reset.
- States (typedef ser_state_t): LOAD, SHIFT.
- LOAD:
  - ser_ready_in=1, ser_valid_out=0.
  - Accept when ser_ready_in & (&ser_valid_in). On accept: buf<=ser_data_in, idx<=0, state<=SHIFT.
  - Partial valid (some but not all bits set) is not accepted; the block stays in LOAD.
- SHIFT:
  - ser_valid_out=1, ser_data_out=buf[idx], ser_channel_out=idx, ser_last_out=(idx==NUM_CHANNELS-1).
  - Beat completes when ser_ready_out=1: idx<=idx+1.
  - On the last beat completing: idx<=0, state<=LOAD, unless a new vector is accepted in the same cycle (see below).
- Back-to-back: ser_ready_in = (state==LOAD) | (state==SHIFT & ser_last_out & ser_ready_out).
  - This is combinational from ser_ready_out.
  - If a full vector is accepted on the last beat: buf reloads, idx<=0, state stays SHIFT. No bubble between vectors.
- Latency: vector accepted at edge N gives channel 0 valid in the cycle after edge N. A full vector with no stalls drains in NUM_CHANNELS cycles.
- Stall: while ser_valid_out=1 and ser_ready_out=0, data, channel and last hold stable. Upstream is held off (ser_ready_in=0).
- Outputs when not valid: ser_data_out, ser_channel_out and ser_last_out are forced to 0 whenever ser_valid_out=0.
- Reset mid-SHIFT: the remaining beats are discarded. The next cycle after rst deasserts, state is LOAD with ser_ready_in=1.
- idx never wraps past NUM_CHANNELS-1. Non-power-of-2 NUM_CHANNELS is supported.

Optional Feature:
- Macro: CONV1D_SER_VALID_CHECK_EN.
- Defined: in any cycle where ser_valid_in is neither all-zeros nor all-ones, ser_error<=1.
  - The flag is sticky until rst and is checked in both states.
  - Mismatched vectors are still not accepted.
- Undefined: no check logic; ser_error is constant 0.

Decomposition:
- Shared cnn1d_pkg gets the ser_state_t enum {LOAD, SHIFT}. The existing clog2 function there is reused for COUNTER_WIDTH.
- No sub-module: buffer, index counter and two-state FSM are implemented inline in one module.

Test Plan:
All scenarios use NUM_CHANNELS=4, DATA_WIDTH=8.
1. Reset: hold rst 3 cycles with ser_valid_in=4'b1111 -> ser_ready_in=0, ser_valid_out=0, ser_error=0. Cycle after release -> ser_ready_in=1.
2. Single vector {11,22,33,44} hex, ser_ready_out=1:
   - Accept, then 4 consecutive beats data 11,22,33,44 with channel 0..3.
   - last=1 only on 44; ser_ready_in=0 during beats 11..33.
3. Backpressure on the same vector: ser_ready_out pattern 1,0,0,1,0,1,1 -> each word held stable while ready=0. Order and last are unchanged; exactly 4 transfers.
4. Back-to-back: vector A {01,02,03,04}, then B {05,06,07,08} kept valid -> B accepted on A's last beat. 8 consecutive valid beats 01..08, last on 04 and 08.
5. Partial valid 4'b0111 for 5 cycles -> no accept, ser_valid_out stays 0. With the macro, ser_error=1 from the cycle after the first mismatch until rst.
6. Reset mid-operation: assert rst while channel 2 of {AA,BB,CC,DD} is presented -> next cycle ser_valid_out=0. A new vector {10,20,30,40} then streams starting at channel 0.
